merge_table_ctrl: RTL

Sequencer and arbiter for the single-port connected-component merge table. It owns the table's only memory port. At frame start it initialises the table to identity. During the frame it grants the labeler exclusive access. At frame end it runs a flattening pass, so every entry points directly at its root label. It then serves the output colour-lookup stage until the next frame. It sits between the labeler (merge writes), the merge-table RAM and the colour-table lookup.

---
 rtl/cc_pkg.sv | 7 +
 rtl/merge_table_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cc_pkg.sv
// Shared types for the connected-component labelling blocks.
package cc_pkg;
  localparam int DEF_LABEL_W = 8;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_STREAM, S_FLATTEN, S_READY} mtc_state_t;
  typedef enum logic [1:0] {RD_I, RD_P, WR} flat_phase_t;
endpackage

// File: rtl/merge_table_ctrl.sv
// Sole owner of the merge-table RAM port: identity init, labeler window,
// single-pass flatten to roots, then pipelined root lookups.
module merge_table_ctrl
  import cc_pkg::*;
#(
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int DEPTH   = 2**LABEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               frame_done,
  input  logic [LABEL_W-1:0] max_label,
  input  logic               lab_req,
  input  logic               lab_we,
  input  logic [LABEL_W-1:0] lab_addr,
  input  logic [LABEL_W-1:0] lab_wdata,
  output logic               lab_gnt,
  output logic [LABEL_W-1:0] lab_rdata,
  input  logic               lu_req,
  input  logic [LABEL_W-1:0] lu_addr,
  output logic               lu_valid,
  output logic [LABEL_W-1:0] lu_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [LABEL_W-1:0] mem_addr,
  output logic [LABEL_W-1:0] mem_wdata,
  input  logic [LABEL_W-1:0] mem_rdata,
  output logic               busy,
  output logic               flat_done
);

  localparam logic [LABEL_W-1:0] LAST = LABEL_W'(DEPTH-1);

  mtc_state_t         state;
  flat_phase_t        phase;
  logic [LABEL_W-1:0] ptr;        // init_ptr in INIT, label i in FLATTEN
  logic [LABEL_W-1:0] max_r;
  logic [LABEL_W-1:0] max_sat;
  logic               lab_rd_vld;

  assign max_sat = (int'(max_label) > DEPTH-1) ? LAST : max_label;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= RD_I;
      ptr        <= '0;
      max_r      <= '0;
      flat_done  <= 1'b0;
      lu_valid   <= 1'b0;
      lab_rd_vld <= 1'b0;
    end else begin
      flat_done  <= 1'b0;
      // a lookup issued in the last READY cycle still completes across vsync
      lu_valid   <= (state == S_READY) && lu_req;
      lab_rd_vld <= (state == S_STREAM) && lab_req && !lab_we;
      if (vsync) begin
        state <= S_INIT;
        ptr   <= '0;
        phase <= RD_I;
      end else begin
        case (state)
          S_INIT: begin
            if (ptr == LAST) state <= S_STREAM;
            else             ptr   <= ptr + LABEL_W'(1);
          end
          S_STREAM: begin
            if (frame_done) begin
              max_r <= max_sat;
              if (max_sat == '0) begin
                state     <= S_READY;
                flat_done <= 1'b1;
              end else begin
                state <= S_FLATTEN;
                ptr   <= LABEL_W'(1);
                phase <= RD_I;
              end
            end
          end
          S_FLATTEN: begin
            case (phase)
              RD_I: phase <= RD_P;
              RD_P: phase <= WR;
              default: begin
                phase <= RD_I;
                if (ptr == max_r) begin
                  state     <= S_READY;
                  flat_done <= 1'b1;
                end else begin
                  ptr <= ptr + LABEL_W'(1);
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Parents never exceed their child, so mem[p] is already a root when label i is visited.
  always_comb begin
    lab_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = ptr;
      end
      S_STREAM: begin
        lab_gnt   = lab_req;
        mem_en    = lab_req;
        mem_we    = lab_req && lab_we;
        mem_addr  = lab_addr;
        mem_wdata = lab_wdata;
      end
      S_FLATTEN: begin
        mem_en = 1'b1;
        case (phase)
          RD_I: mem_addr = ptr;
          RD_P: mem_addr = mem_rdata;
          default: begin
            mem_we    = 1'b1;
            mem_addr  = ptr;
            mem_wdata = mem_rdata;
          end
        endcase
      end
      S_READY: begin
        mem_en   = lu_req;
        mem_addr = lu_addr;
      end
      default: ;
    endcase
  end

  assign busy      = (state == S_INIT) || (state == S_FLATTEN);
  assign lu_rdata  = lu_valid   ? mem_rdata : '0;
  assign lab_rdata = lab_rd_vld ? mem_rdata : '0;

endmodule
